dobby_fetch_queue: RTL
======================

# dobby_fetch_queue

Parametrised instruction prefetch queue between the bus interface and the decoder. It replaces the single-entry hold-instruction registers of the current core with a DEPTH-entry in-order buffer. It issues sequential fetch requests with credit-based flow control, tags each instruction with its PC, and on a redirect (jump, trap, interrupt) flushes the queue and silently discards responses still in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; PC step is DATA_WIDTH/8.
- ADDR_WIDTH, 16, fetch address width, matching the bus address.
- DEPTH, 4, queue entries (power of two, ≥2); also the maximum number of outstanding requests.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  core clock.
- a_reset_l  in  1  reset; one clock, reset is synchronous and active-low.
- i_flush  in  1  redirect strobe (one cycle).
- i_flush_pc  in  ADDR_WIDTH  redirect target.
- o_req  out  1  fetch request valid.
- o_req_addr  out  ADDR_WIDTH  fetch address.
- i_req_ready  in  1  bus accepts request this cycle.
- i_rsp_valid  in  1  in-order response strobe, exactly one per accepted request.
- i_rsp_data  in  DATA_WIDTH  fetched word.
- o_inst_valid  out  1  head entry valid.
- o_inst  out  DATA_WIDTH  head instruction.
- o_inst_pc  out  ADDR_WIDTH  head PC.
- i_inst_ready  in  1  decoder consumes head (stall = low).
- o_level  out  clog2(DEPTH+1)  occupied entries.

## Operation
- Counters: level (entries held), outst (accepted requests, response pending, not discarded), disc (responses to drop), fetch_pc, rsp_pc.
- o_req = !i_flush && (level + outst) < DEPTH; o_req_addr = fetch_pc. Accept = o_req && i_req_ready: fetch_pc += DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH), outst++.
- Response with disc > 0: dropped, disc--. Otherwise: push {i_rsp_data, rsp_pc}, rsp_pc += step, outst--.
- Pop = o_inst_valid && i_inst_ready; head advances, level--.
- Push and pop same cycle: level unchanged. Credit rule guarantees a push never hits a full queue. A response with outst = disc = 0 is a protocol error; it is ignored.
- Flush: next cycle level = 0, fetch_pc = rsp_pc = i_flush_pc, disc = disc + outst (counting a same-cycle accepted request and excluding a same-cycle arriving response), outst = 0. A response arriving in the flush cycle is dropped. A pop in the flush cycle is ignored. No request is issued in the flush cycle.
- Flush during a discard drain accumulates into disc. Requests to the new target issue immediately after flush, provided disc + outst < DEPTH, because discarded responses still hold credits.

## Timing
- Reset values: o_req 0, o_req_addr RESET_PC, o_inst_valid 0, o_inst 0, o_inst_pc RESET_PC, o_level 0. All counters 0; fetch_pc = rsp_pc = RESET_PC.
- First o_req in the cycle after a_reset_l deasserts.
- Latency from response to o_inst_valid: 1 cycle (registered push, no bypass).
- After a flush: o_inst_valid low for at least 1 cycle, then the first new instruction appears 1 cycle after its response.
- Reset mid-operation discards everything, including in-flight responses. The bus interface is reset with the same reset.
- Sustained throughput: 1 instruction per cycle when the bus response latency is at most DEPTH−1.

## Structure
- Shared package dobby_pkg holds the defaults (XLEN = 32, BUS_ADDR_W = 16, INST_STEP) and a clog2 helper constant function.
- Sub-module dobby_sync_fifo is a parametrised width/depth circular buffer with push/pop/flush, pointer wrap and a level output. This block adds the credit, discard and PC logic around it.

## Test plan
- Reset release with the bus always ready and a 1-cycle response: requests at 0x0, 0x4, 0x8, …, and o_inst_pc 0x0, 0x4 in consecutive cycles from cycle 3.
- DEPTH = 4, i_inst_ready held low: exactly 4 requests accepted, o_req drops, o_level = 4. A single pop produces exactly one new request.
- 3 requests outstanding, then flush to 0x0100: the 3 old responses are dropped, first o_inst_pc = 0x0100, and no stale word is ever presented.
- Flush, with a response and a pop in the same cycle, then a second flush during the drain: disc accumulates correctly and only the final target's instructions appear.
- fetch_pc = 0xFFFC: next request at 0x0000, with the PC tags wrapping the same way.
- a_reset_l asserted with 2 requests outstanding: all outputs return to their reset values, and late responses after reset are ignored by the bench model.

Source files
------------

// File: rtl/dobby_pkg.sv
// Shared defaults for the dobby core fetch path and a constant log2 helper
// used to size pointers and occupancy counters.
package dobby_pkg;

    localparam int XLEN       = 32;
    localparam int BUS_ADDR_W = 16;
    localparam int INST_STEP  = XLEN / 8;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dobby_sync_fifo.sv
// Circular buffer with push/pop/flush and an occupancy level; the head entry
// is read straight from storage so a push shows up one cycle later.
module dobby_sync_fifo
    import dobby_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         a_reset_l,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [clog2(DEPTH + 1)-1:0]  level
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int LVL_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && (count < LVL_W'(DEPTH));
    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];
    assign level     = count;

    always_ff @(posedge clk) begin
        if (!a_reset_l || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush && a_reset_l) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dobby_fetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, PC tagging and
// redirect handling that drops responses still in flight at the flush.
module dobby_fetch_queue
    import dobby_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = BUS_ADDR_W,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         a_reset_l,
    input  logic                         i_flush,
    input  logic [ADDR_WIDTH-1:0]        i_flush_pc,
    output logic                         o_req,
    output logic [ADDR_WIDTH-1:0]        o_req_addr,
    input  logic                         i_req_ready,
    input  logic                         i_rsp_valid,
    input  logic [DATA_WIDTH-1:0]        i_rsp_data,
    output logic                         o_inst_valid,
    output logic [DATA_WIDTH-1:0]        o_inst,
    output logic [ADDR_WIDTH-1:0]        o_inst_pc,
    input  logic                         i_inst_ready,
    output logic [clog2(DEPTH + 1)-1:0]  o_level
);

    localparam int LVL_W = clog2(DEPTH + 1);
    localparam int SUM_W = LVL_W + 2;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic                          run_q;
    logic [LVL_W-1:0]              outst_q;
    logic [LVL_W-1:0]              disc_q;
    logic [ADDR_WIDTH-1:0]         fetch_pc_q;
    logic [ADDR_WIDTH-1:0]         rsp_pc_q;
    logic [LVL_W-1:0]              level;
    logic [SUM_W-1:0]              credit_used;
    logic                          accept;
    logic                          rsp_drop;
    logic                          rsp_push;
    logic                          rsp_any;
    logic                          pop;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] head;

    // Discarded responses still occupy bus slots, so they count against credit.
    assign credit_used = SUM_W'(level) + SUM_W'(outst_q) + SUM_W'(disc_q);
    assign o_req       = run_q && !i_flush && (credit_used < SUM_W'(DEPTH));
    assign o_req_addr  = fetch_pc_q;
    assign accept      = o_req && i_req_ready;

    assign rsp_any  = i_rsp_valid && ((disc_q != '0) || (outst_q != '0));
    assign rsp_drop = i_rsp_valid && (disc_q != '0);
    assign rsp_push = i_rsp_valid && (disc_q == '0) && (outst_q != '0) && !i_flush;

    assign o_inst_valid = (level != '0);
    assign pop          = o_inst_valid && i_inst_ready && !i_flush;
    assign o_inst       = o_inst_valid ? head[DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH] : '0;
    assign o_inst_pc    = o_inst_valid ? head[ADDR_WIDTH-1:0] : rsp_pc_q;
    assign o_level      = level;

    dobby_sync_fifo #(
        .WIDTH (DATA_WIDTH + ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .a_reset_l (a_reset_l),
        .flush     (i_flush),
        .push      (rsp_push),
        .push_data ({i_rsp_data, rsp_pc_q}),
        .pop       (pop),
        .head_data (head),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (!a_reset_l) begin
            run_q      <= 1'b0;
            outst_q    <= '0;
            disc_q     <= '0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
        end else begin
            run_q <= 1'b1;
            if (i_flush) begin
                fetch_pc_q <= i_flush_pc;
                rsp_pc_q   <= i_flush_pc;
                outst_q    <= '0;
                disc_q     <= disc_q + outst_q + LVL_W'(accept) - LVL_W'(rsp_any);
            end else begin
                if (accept) begin
                    fetch_pc_q <= fetch_pc_q + STEP;
                end
                if (rsp_push) begin
                    rsp_pc_q <= rsp_pc_q + STEP;
                end
                outst_q <= outst_q + LVL_W'(accept) - LVL_W'(rsp_push);
                disc_q  <= disc_q - LVL_W'(rsp_drop);
            end
        end
    end

endmodule
